// File: rtl/uart_send.sv
// UART transmitter: one 8-bit byte per request, LSB first, with an optional
// odd/even parity bit and one or two stop bits. Baud timing comes from a
// clock-cycle counter of CLK_FREQ/UART_BPS cycles per bit.
module uart_send #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] BPS_CNT   = 16'(CLK_FREQ / UART_BPS);
  localparam logic [15:0] BPS_LAST  = BPS_CNT - 16'd1;
  localparam logic        PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam logic        PAR_ODD   = (PARITY == 1);
  localparam logic [2:0]  STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]  state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  data_reg;
  logic        par_reg;
  logic        bit_end;

  // Last cycle of the current bit period.
  always_comb begin
    bit_end = (clk_cnt == BPS_LAST);
  end

  // Busy whenever a frame is on the line; drops in the tx_done cycle.
  always_comb begin
    tx_busy = (state != ST_IDLE);
  end

  // Frame sequencer: bit timing, shift register and registered line output.
  // The data register shifts right so data_reg[0] is always the next data bit;
  // bit_cnt is reused to count stop bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      data_reg <= '0;
      par_reg  <= 1'b0;
      uart_txd <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != ST_IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (send_en) begin
            state    <= ST_START;
            data_reg <= send_data;
            par_reg  <= PAR_ODD ? ~(^send_data) : (^send_data);
            uart_txd <= 1'b0;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            uart_txd <= data_reg[0];
            data_reg <= {1'b0, data_reg[7:1]};
            bit_cnt  <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PAR_EN) begin
                state    <= ST_PARITY;
                uart_txd <= par_reg;
              end else begin
                state    <= ST_STOP;
                uart_txd <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_txd <= data_reg[0];
              data_reg <= {1'b0, data_reg[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            uart_txd <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= ST_IDLE;
              tx_done <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send with 16 cycles per bit. Three instances share stimulus:
// no parity/1 stop, even parity/2 stop, odd parity/1 stop.
module tb_uart_send;

  localparam int BPS = 16;
  localparam int MAXS = 8192;

  logic       clk;
  logic       rst;
  logic       send_en;
  logic [7:0] send_data;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] done;

  int total;
  int passed;
  int pc;

  logic [2:0] tx_l   [MAXS];
  logic [2:0] busy_l [MAXS];
  logic [2:0] done_l [MAXS];

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  vec_t vecs [6];

  uart_send #(.CLK_FREQ(16), .UART_BPS(1), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rst(rst), .send_en(send_en), .send_data(send_data),
    .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_send #(.CLK_FREQ(16), .UART_BPS(1), .PARITY(2), .STOP_BITS(2)) u_even (
    .clk(clk), .rst(rst), .send_en(send_en), .send_data(send_data),
    .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_send #(.CLK_FREQ(16), .UART_BPS(1), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .send_en(send_en), .send_data(send_data),
    .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: sample index k holds the state left by the k-th rising edge.
  always @(posedge clk) pc <= pc + 1;

  // Record outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pc >= 0 && pc < MAXS) begin
      tx_l[pc]   <= txd;
      busy_l[pc] <= busy;
      done_l[pc] <= done;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Count samples of one output equal to val over [lo, hi]. which: 0 txd, 1 busy, 2 done.
  function automatic int cnt(input int which, input int inst, input int lo, input int hi,
                             input logic val);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      logic s;
      if (which == 0) s = tx_l[i][inst];
      else if (which == 1) s = busy_l[i][inst];
      else s = done_l[i][inst];
      if (s == val) n++;
    end
    return n;
  endfunction

  // Mid-bit sampling of the 8 data bits of a frame whose start bit begins at s.
  function automatic logic [7:0] decode(input int inst, input int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tx_l[s + BPS * (k + 1) + BPS / 2][inst];
    return b;
  endfunction

  task automatic send(input logic [7:0] b, input bit hold, output int e0);
    @(negedge clk);
    send_en   = 1'b1;
    send_data = b;
    @(posedge clk);
    #1;
    e0 = pc;
    if (!hold) send_en = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every bit of the frame held for exactly BPS samples, then done/busy timing.
  task automatic check_frame(input string tag, input int inst, input int e0,
                             input logic [11:0] frame, input int nbits);
    int fend;
    fend = e0 + nbits * BPS;
    for (int k = 0; k < nbits; k++)
      chk($sformatf("%s bit%0d", tag, k),
          BPS - cnt(0, inst, e0 + k * BPS, e0 + k * BPS + BPS - 1, frame[k]), 0);
    chk({tag, " done_at_end"}, int'(done_l[fend][inst]), 1);
    chk({tag, " done_count"}, cnt(2, inst, e0, fend + 20, 1'b1), 1);
    chk({tag, " busy_cycles"}, cnt(1, inst, e0 - 1, fend + 20, 1'b1), nbits * BPS);
    chk({tag, " idle_high"}, cnt(0, inst, fend, fend + 20, 1'b0), 0);
  endtask

  initial begin
    int e0;
    int s;
    total     = 0;
    passed    = 0;
    pc        = 0;
    rst       = 1'b1;
    send_en   = 1'b0;
    send_data = 8'h00;

    vecs[0] = '{data: 8'h55, par_even: 1'b0, par_odd: 1'b1};
    vecs[1] = '{data: 8'h03, par_even: 1'b0, par_odd: 1'b1};
    vecs[2] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1};
    vecs[3] = '{data: 8'h07, par_even: 1'b1, par_odd: 1'b0};
    vecs[4] = '{data: 8'h80, par_even: 1'b1, par_odd: 1'b0};
    vecs[5] = '{data: 8'hFE, par_even: 1'b1, par_odd: 1'b0};

    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);

    // Reset asserted mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("reset txd", int'(txd), 7);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    wait_cycles(2);
    rst = 1'b0;
    s = pc;
    wait_cycles(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("idle line u%0d", i), cnt(0, i, s, s + 18, 1'b0), 0);
      chk($sformatf("idle done u%0d", i), cnt(2, i, s, s + 18, 1'b1), 0);
    end

    // Table of bytes: full frame shape on all three configurations.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, 1'b0, e0);
      wait_cycles(215);
      check_frame($sformatf("v%0d none", v), 0, e0,
                  {2'b11, 1'b1, vecs[v].data, 1'b0}, 10);
      check_frame($sformatf("v%0d even", v), 1, e0,
                  {1'b1, 1'b1, vecs[v].par_even, vecs[v].data, 1'b0}, 12);
      check_frame($sformatf("v%0d odd", v), 2, e0,
                  {1'b1, 1'b1, vecs[v].par_odd, vecs[v].data, 1'b0}, 11);
    end

    // Request during a busy frame is dropped, not queued.
    send(8'hA5, 1'b0, e0);
    wait_cycles(39);
    send_en   = 1'b1;
    send_data = 8'hFF;
    wait_cycles(1);
    send_en = 1'b0;
    wait_cycles(250);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ignored data u%0d", i), int'(decode(i, e0)), 8'hA5);
      chk($sformatf("ignored done u%0d", i), cnt(2, i, e0, e0 + 260, 1'b1), 1);
    end
    chk("ignored no 2nd frame", cnt(0, 0, e0 + 160, e0 + 260, 1'b0), 0);

    // Back-to-back with send_en held high: restart on the edge after tx_done.
    send(8'h12, 1'b1, e0);
    send_data = 8'h34;
    wait_cycles(162);
    send_en = 1'b0;
    wait_cycles(190);
    chk("b2b done at 160", int'(done_l[e0 + 160][0]), 1);
    chk("b2b busy low at 160", int'(busy_l[e0 + 160][0]), 0);
    chk("b2b line high at 160", int'(tx_l[e0 + 160][0]), 1);
    chk("b2b start at 161", int'(tx_l[e0 + 161][0]), 0);
    chk("b2b first byte", int'(decode(0, e0)), 8'h12);
    chk("b2b second byte", int'(decode(0, e0 + 161)), 8'h34);
    chk("b2b done count", cnt(2, 0, e0, e0 + 340, 1'b1), 2);
    chk("b2b second done", int'(done_l[e0 + 321][0]), 1);

    // Reset mid-frame: line high immediately, frame abandoned.
    send(8'h00, 1'b0, e0);
    wait_cycles(69);
    chk("midreset line low before", int'(txd), 0);
    #2 rst = 1'b1;
    #1;
    chk("midreset line high", int'(txd), 7);
    chk("midreset busy", int'(busy), 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(200);
    for (int i = 0; i < 3; i++)
      chk($sformatf("midreset no done u%0d", i), cnt(2, i, e0, e0 + 270, 1'b1), 0);
    chk("midreset idle after", cnt(0, 0, e0 + 75, e0 + 270, 1'b0), 0);

    // Loopback-style decode of a complete frame.
    send(8'hC3, 1'b0, e0);
    wait_cycles(215);
    for (int i = 0; i < 3; i++)
      chk($sformatf("loopback u%0d", i), int'(decode(i, e0)), 8'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
